cacheline_line_buffer: RTL and testbench
========================================

Name: cacheline_line_buffer

Overview:
- Parametrised line buffer between the L2 cache controller and a narrow burst memory port.
- Writebacks: serialises one full cacheline into BEATS beats of BEAT_WIDTH.
- Fetches: deserialises returned beats into a full cacheline, then holds it for the controller under a valid/ready handshake.
- Generalises the fixed 256-bit line path to any line/beat width ratio, with optional critical-word-first fetch.

Parameters:
- LINE_WIDTH, 256: cacheline bits (CACHELINE_SIZE).
- BEAT_WIDTH, 64: memory beat bits. LINE_WIDTH/BEAT_WIDTH = BEATS, a power of two ≥2.
- ADDR_WIDTH, 32: byte address width (XLEN).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- line_req_valid  in  1  controller request.
- line_req_ready  out  1  buffer accepts request.
- line_req_write  in  1  1 = writeback, 0 = fetch.
- line_req_addr  in  ADDR_WIDTH  request byte address.
- line_req_wdata  in  LINE_WIDTH  writeback line.
- line_resp_valid  out  1  fetched line available.
- line_resp_ready  in  1  controller takes fetched line.
- line_resp_rdata  out  LINE_WIDTH  fetched line.
- line_write_done  out  1  one-cycle pulse, writeback finished.
- mem_read  out  1  burst read request.
- mem_write  out  1  write beat valid.
- mem_addr  out  ADDR_WIDTH  burst start byte address.
- mem_wdata  out  BEAT_WIDTH  write beat.
- mem_ready  in  1  memory accepts read request or write beat.
- mem_rvalid  in  1  read beat valid.
- mem_rdata  in  BEAT_WIDTH  read beat.

Behaviour:
- Single clock domain. Reset is synchronous and active-low.
- States come from line_buffer_state_t: LINE_IDLE, WAIT, SERIALIZE, DESERIALIZE, DESERIALIZE_DONE.
- Beat counter width is log2(BEATS). Beat i occupies line bits [i*BEAT_WIDTH +: BEAT_WIDTH].
- Reset, including mid-operation: state LINE_IDLE, counter 0. line_req_ready=1; every other output 0, data outputs included. Partial line data is discarded.
- LINE_IDLE:
  - line_req_ready=1. On valid&ready, latch addr and wdata.
  - Aligned address = addr with the low log2(LINE_WIDTH/8) bits cleared.
  - Write goes to SERIALIZE; read goes to WAIT.
- line_req_ready=0 in every other state. Requests there are ignored.
- SERIALIZE:
  - mem_write=1, mem_addr=aligned address, mem_wdata=beat[counter].
  - Each cycle with mem_ready=1 advances the counter.
  - When the last beat is accepted: go to LINE_IDLE; line_write_done=1 for exactly the next cycle; counter wraps to 0.
  - mem_ready=0 holds all outputs stable.
- WAIT:
  - mem_read=1, mem_addr=burst start address; held until mem_ready=1, then go to DESERIALIZE.
  - Counter loads start beat (0 without the option).
- DESERIALIZE:
  - Each mem_rvalid=1 writes mem_rdata into beat[counter]; counter increments modulo BEATS.
  - After BEATS beats, go to DESERIALIZE_DONE.
  - mem_rvalid in any other state is ignored.
- DESERIALIZE_DONE:
  - line_resp_valid=1 and line_resp_rdata stable until line_resp_ready=1, then LINE_IDLE.
  - Response registered, 1-cycle latency after the last beat.
  - line_resp_ready sampled in the same cycle valid rises is honoured.
- Latency, zero-wait memory:
  - Write: BEATS cycles of mem_write plus a done pulse.
  - Read: 1 request cycle, BEATS beat cycles, then resp_valid.
- No back-to-back overlap. A new request is accepted only in LINE_IDLE, earliest the cycle after done/handshake.

Optional Feature:
- Macro: LINE_BUF_CWF_EN.
- Defined (critical-word-first fetch):
  - start beat = addr[log2(LINE_WIDTH/8)-1 : log2(BEAT_WIDTH/8)].
  - mem_addr = aligned address + start beat × BEAT_WIDTH/8.
  - Beats are placed starting at the start beat and wrap past BEATS-1 to 0.
  - Writebacks are unaffected and always start at beat 0.
- Undefined: start beat is always 0 and mem_addr is the aligned address for both directions.

Test Plan:
- Writeback, addr 0x0000_1234, wdata beats {D3,D2,D1,D0}, mem_ready=1:
  - mem_addr=0x0000_1220; mem_wdata D0,D1,D2,D3 on 4 consecutive cycles.
  - line_write_done pulses once; ready returns to 1.
- Fetch, addr 0x0000_1240, mem_ready delayed 3 cycles, beats A,B,C,D with one idle gap:
  - mem_read held 3 cycles.
  - line_resp_rdata={D,C,B,A}; resp_valid held 5 cycles while resp_ready=0.
- Writeback with mem_ready toggling 1,0,1,0…:
  - Each beat is held stable while not accepted; exactly 4 beats are issued.
- Reset asserted during DESERIALIZE after 2 beats:
  - Next cycle: LINE_IDLE, all outputs 0 except line_req_ready=1.
  - A following fetch returns only new data.
- line_req_valid asserted during SERIALIZE and spurious mem_rvalid during WAIT:
  - Request not accepted; stray beat not captured.
- With LINE_BUF_CWF_EN, fetch addr 0x0000_1258:
  - mem_addr=0x0000_1258; first beat lands in beat 3, then beats 0,1,2.
  - Line matches the memory image.

Source files
------------

// File: rtl/cacheline_line_buffer.sv
// Line buffer between the L2 controller and a narrow burst memory port: serialises writebacks, deserialises fetches.
// Optional critical-word-first fetch is enabled by defining LINE_BUF_CWF_EN.
module cacheline_line_buffer #(
    parameter int LINE_WIDTH = 256,
    parameter int BEAT_WIDTH = 64,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  line_req_valid,
    output logic                  line_req_ready,
    input  logic                  line_req_write,
    input  logic [ADDR_WIDTH-1:0] line_req_addr,
    input  logic [LINE_WIDTH-1:0] line_req_wdata,
    output logic                  line_resp_valid,
    input  logic                  line_resp_ready,
    output logic [LINE_WIDTH-1:0] line_resp_rdata,
    output logic                  line_write_done,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [BEAT_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ready,
    input  logic                  mem_rvalid,
    input  logic [BEAT_WIDTH-1:0] mem_rdata
);

    localparam int BEATS  = LINE_WIDTH / BEAT_WIDTH;
    localparam int CNT_W  = $clog2(BEATS);
    localparam int OFF_W  = $clog2(LINE_WIDTH / 8);
    localparam int BOFF_W = $clog2(BEAT_WIDTH / 8);
`ifdef LINE_BUF_CWF_EN
    // Fetches keep the beat-select bits so the burst starts at the critical beat.
    localparam int FETCH_OFF_W = BOFF_W;
`else
    localparam int FETCH_OFF_W = OFF_W;
`endif
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK  = ~ADDR_WIDTH'((1 << OFF_W) - 1);
    localparam logic [ADDR_WIDTH-1:0] FETCH_MASK = ~ADDR_WIDTH'((1 << FETCH_OFF_W) - 1);
    localparam logic [CNT_W-1:0]      LAST_BEAT  = CNT_W'(BEATS - 1);

    typedef enum logic [2:0] {
        LINE_IDLE,
        WAIT,
        SERIALIZE,
        DESERIALIZE,
        DESERIALIZE_DONE
    } line_buffer_state_t;

    line_buffer_state_t    state;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      rcv;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  write_done_q;
    logic [BEAT_WIDTH-1:0] buf_q [BEATS];

    always_ff @(posedge clk) begin
        // NOTE: the line storage is cleared on reset too, so a partial fetch can never leak out later.
        if (!rst_n) begin
            state        <= LINE_IDLE;
            cnt          <= '0;
            rcv          <= '0;
            addr_q       <= '0;
            write_done_q <= 1'b0;
            for (int i = 0; i < BEATS; i++) buf_q[i] <= '0;
        end else begin
            write_done_q <= 1'b0;
            case (state)
                LINE_IDLE: begin
                    if (line_req_valid) begin
                        for (int i = 0; i < BEATS; i++)
                            buf_q[i] <= line_req_wdata[i*BEAT_WIDTH +: BEAT_WIDTH];
                        cnt <= '0;
                        rcv <= '0;
                        if (line_req_write) begin
                            addr_q <= line_req_addr & LINE_MASK;
                            state  <= SERIALIZE;
                        end else begin
                            addr_q <= line_req_addr & FETCH_MASK;
                            state  <= WAIT;
                        end
                    end
                end
                SERIALIZE: begin
                    if (mem_ready) begin
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == LAST_BEAT) begin
                            state        <= LINE_IDLE;
                            write_done_q <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    // Beat-select bits are zero unless critical-word-first kept them.
                    if (mem_ready) begin
                        cnt   <= addr_q[OFF_W-1:BOFF_W];
                        state <= DESERIALIZE;
                    end
                end
                DESERIALIZE: begin
                    if (mem_rvalid) begin
                        buf_q[cnt] <= mem_rdata;
                        cnt        <= cnt + CNT_W'(1);
                        rcv        <= rcv + CNT_W'(1);
                        if (rcv == LAST_BEAT) state <= DESERIALIZE_DONE;
                    end
                end
                DESERIALIZE_DONE: begin
                    if (line_resp_ready) state <= LINE_IDLE;
                end
                default: state <= LINE_IDLE;
            endcase
        end
    end

    // Outputs decode only registered state, so they are glitch-free and zero outside their phase.
    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        line_req_ready  = (state == LINE_IDLE);
        line_resp_valid = (state == DESERIALIZE_DONE);
        line_write_done = write_done_q;
        mem_read        = (state == WAIT);
        mem_write       = (state == SERIALIZE);
        mem_addr        = '0;
        mem_wdata       = '0;
        line_resp_rdata = '0;
        if (state == SERIALIZE || state == WAIT) mem_addr = addr_q;
        if (state == SERIALIZE) mem_wdata = buf_q[cnt];
        if (state == DESERIALIZE_DONE) begin
            for (int i = 0; i < BEATS; i++)
                line_resp_rdata[i*BEAT_WIDTH +: BEAT_WIDTH] = buf_q[i];
        end
    end

endmodule

// File: tb/tb_cacheline_line_buffer.sv
// Directed self-checking bench for cacheline_line_buffer (256-bit line, 64-bit beats).
module tb_cacheline_line_buffer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         line_req_valid, line_req_ready, line_req_write;
    logic [31:0]  line_req_addr;
    logic [255:0] line_req_wdata;
    logic         line_resp_valid, line_resp_ready;
    logic [255:0] line_resp_rdata;
    logic         line_write_done;
    logic         mem_read, mem_write;
    logic [31:0]  mem_addr;
    logic [63:0]  mem_wdata;
    logic         mem_ready, mem_rvalid;
    logic [63:0]  mem_rdata;

    int total = 0;
    int bad   = 0;

    cacheline_line_buffer dut (
        .clk(clk), .rst_n(rst_n),
        .line_req_valid(line_req_valid), .line_req_ready(line_req_ready),
        .line_req_write(line_req_write), .line_req_addr(line_req_addr),
        .line_req_wdata(line_req_wdata),
        .line_resp_valid(line_resp_valid), .line_resp_ready(line_resp_ready),
        .line_resp_rdata(line_resp_rdata), .line_write_done(line_write_done),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_req_ready"}, 256'(line_req_ready), 256'(1));
        check({tag, "_resp_valid"}, 256'(line_resp_valid), 256'(0));
        check({tag, "_done"}, 256'(line_write_done), 256'(0));
        check({tag, "_mem_read"}, 256'(mem_read), 256'(0));
        check({tag, "_mem_write"}, 256'(mem_write), 256'(0));
        check({tag, "_mem_addr"}, 256'(mem_addr), 256'(0));
        check({tag, "_mem_wdata"}, 256'(mem_wdata), 256'(0));
        check({tag, "_rdata"}, line_resp_rdata, 256'(0));
    endtask

    logic [63:0] d [4];
    logic [63:0] e [4];
    logic [63:0] g [4];
    logic [63:0] h [4];
    logic [63:0] m [4];
    int k;

    initial begin
        d = '{64'hD0D0_0000_0000_0000, 64'hD1D1_1111_1111_1111, 64'hD2D2_2222_2222_2222, 64'hD3D3_3333_3333_3333};
        e = '{64'hE000_0000_0000_00E0, 64'hE111_1111_1111_11E1, 64'hE222_2222_2222_22E2, 64'hE333_3333_3333_33E3};
        g = '{64'h6000_0000_0000_0060, 64'h6111_0000_0000_0061, 64'h6222_0000_0000_0062, 64'h6333_0000_0000_0063};
        h = '{64'h4A00_0000_0000_0000, 64'h4A11_0000_0000_0000, 64'h4A22_0000_0000_0000, 64'h4A33_0000_0000_0000};
        m = '{64'h7700_0000_0000_0000, 64'h7711_0000_0000_0000, 64'h7722_0000_0000_0000, 64'h7733_0000_0000_0000};

        rst_n = 1'b0; line_req_valid = 1'b0; line_req_write = 1'b0; line_req_addr = '0;
        line_req_wdata = '0; line_resp_ready = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        tick(); tick();
        check_idle_outputs("reset");
        rst_n = 1'b1;

        // Writeback, zero-wait memory.
        line_req_valid = 1'b1; line_req_write = 1'b1; line_req_addr = 32'h0000_1234;
        line_req_wdata = {d[3], d[2], d[1], d[0]};
        tick();
        line_req_valid = 1'b0; mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("wb_ready_low", 256'(line_req_ready), 256'(0));
            check("wb_mem_write", 256'(mem_write), 256'(1));
            check("wb_mem_addr", 256'(mem_addr), 256'(32'h0000_1220));
            check("wb_wdata", 256'(mem_wdata), 256'(d[i]));
            tick();
        end
        mem_ready = 1'b0;
        check("wb_done_pulse", 256'(line_write_done), 256'(1));
        check("wb_ready_back", 256'(line_req_ready), 256'(1));
        check("wb_write_off", 256'(mem_write), 256'(0));
        tick();
        check("wb_done_once", 256'(line_write_done), 256'(0));

        // Fetch, request accepted on the third WAIT cycle, one idle gap in the beats.
        line_req_valid = 1'b1; line_req_write = 1'b0; line_req_addr = 32'h0000_1240;
        tick();
        line_req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("rd_mem_read", 256'(mem_read), 256'(1));
            check("rd_mem_addr", 256'(mem_addr), 256'(32'h0000_1240));
            if (i == 2) mem_ready = 1'b1;
            tick();
        end
        mem_ready = 1'b0;
        check("rd_read_off", 256'(mem_read), 256'(0));
        mem_rvalid = 1'b1; mem_rdata = 64'hAAAA_0000_0000_000A; tick();
        mem_rdata = 64'hBBBB_0000_0000_000B; tick();
        mem_rvalid = 1'b0; mem_rdata = 64'hDEAD_DEAD_DEAD_DEAD; tick();
        mem_rvalid = 1'b1; mem_rdata = 64'hCCCC_0000_0000_000C; tick();
        check("rd_no_early_valid", 256'(line_resp_valid), 256'(0));
        mem_rdata = 64'hDDDD_0000_0000_000D; tick();
        mem_rvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("rd_resp_valid", 256'(line_resp_valid), 256'(1));
            check("rd_resp_data", line_resp_rdata,
                  {64'hDDDD_0000_0000_000D, 64'hCCCC_0000_0000_000C, 64'hBBBB_0000_0000_000B, 64'hAAAA_0000_0000_000A});
            tick();
        end
        line_resp_ready = 1'b1; tick();
        line_resp_ready = 1'b0;
        check("rd_resp_drop", 256'(line_resp_valid), 256'(0));
        check("rd_ready_back", 256'(line_req_ready), 256'(1));

        // Writeback under a 1,0,1,0 mem_ready pattern.
        line_req_valid = 1'b1; line_req_write = 1'b1; line_req_addr = 32'h0000_2000;
        line_req_wdata = {e[3], e[2], e[1], e[0]};
        tick();
        line_req_valid = 1'b0;
        k = 0;
        for (int c = 0; c < 7; c++) begin
            mem_ready = (c % 2 == 0);
            check("tg_mem_write", 256'(mem_write), 256'(1));
            check("tg_wdata", 256'(mem_wdata), 256'(e[k]));
            tick();
            if (c % 2 == 0) k++;
        end
        mem_ready = 1'b0;
        check("tg_beats", 256'(k), 256'(4));
        check("tg_done", 256'(line_write_done), 256'(1));
        check("tg_write_off", 256'(mem_write), 256'(0));
        tick();

        // Reset in the middle of a fetch, then a clean fetch with a stray beat during WAIT.
        line_req_valid = 1'b1; line_req_write = 1'b0; line_req_addr = 32'h0000_3000; mem_ready = 1'b1;
        tick();
        line_req_valid = 1'b0;
        tick();
        mem_ready = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 64'hF0F0_F0F0_F0F0_F0F0; tick();
        mem_rdata = 64'hF1F1_F1F1_F1F1_F1F1; tick();
        mem_rvalid = 1'b0; rst_n = 1'b0;
        tick();
        check_idle_outputs("midrst");
        rst_n = 1'b1;
        line_req_valid = 1'b1; line_req_addr = 32'h0000_3000;
        tick();
        line_req_valid = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
        tick();
        check("stray_still_wait", 256'(mem_read), 256'(1));
        mem_rvalid = 1'b0; mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_rvalid = 1'b1; mem_rdata = g[i];
            if (i == 3) line_resp_ready = 1'b1;
            tick();
        end
        mem_rvalid = 1'b0;
        check("newfetch_valid", 256'(line_resp_valid), 256'(1));
        check("newfetch_data", line_resp_rdata, {g[3], g[2], g[1], g[0]});
        tick();
        line_resp_ready = 1'b0;
        check("same_cycle_ready", 256'(line_resp_valid), 256'(0));

        // Request while serialising must be ignored.
        line_req_valid = 1'b1; line_req_write = 1'b1; line_req_addr = 32'h0000_4000;
        line_req_wdata = {h[3], h[2], h[1], h[0]};
        tick();
        line_req_write = 1'b0;
        check("busy_ready_low", 256'(line_req_ready), 256'(0));
        tick();
        check("busy_still_write", 256'(mem_write), 256'(1));
        check("busy_no_read", 256'(mem_read), 256'(0));
        check("busy_held_beat", 256'(mem_wdata), 256'(h[0]));
        line_req_valid = 1'b0; mem_ready = 1'b1;
        tick(); tick(); tick(); tick();
        mem_ready = 1'b0;
        check("busy_done", 256'(line_write_done), 256'(1));
        tick();
        check("busy_idle", 256'(mem_read), 256'(0));

        // Fetch of an unaligned address: critical beat first when the option is built in.
        line_req_valid = 1'b1; line_req_addr = 32'h0000_1258;
        tick();
        line_req_valid = 1'b0;
`ifdef LINE_BUF_CWF_EN
        check("cwf_mem_addr", 256'(mem_addr), 256'(32'h0000_1258));
`else
        check("cwf_mem_addr", 256'(mem_addr), 256'(32'h0000_1240));
`endif
        mem_ready = 1'b1; tick();
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_rvalid = 1'b1; mem_rdata = m[i]; tick();
        end
        mem_rvalid = 1'b0;
`ifdef LINE_BUF_CWF_EN
        check("cwf_line", line_resp_rdata, {m[0], m[3], m[2], m[1]});
`else
        check("cwf_line", line_resp_rdata, {m[3], m[2], m[1], m[0]});
`endif
        line_resp_ready = 1'b1; tick();
        line_resp_ready = 1'b0;
        check("cwf_release", 256'(line_req_ready), 256'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench time limit reached");
    end

endmodule
